// File: rtl/delay_line_read_seq.sv
// Read-side address sequencer for the circular sample delay line: walks back
// from the newest sample for TAPS reads and hands each address over valid/ready.
module delay_line_read_seq #(
  parameter int ADDR_W = 3,
  parameter int TAPS   = 3,
  parameter int TAP_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [TAP_W-1:0]  TAP_ONE  = TAP_W'(1);

  state_t              state_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [TAP_W-1:0]    tap_idx_q;
  logic                rd_valid_q;
  logic                rd_last_q;
  logic                busy_q;
  logic                done_q;

  // rd_valid is only ever high in RUN, so rd_ready alone marks a transfer there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      tap_idx_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rd_addr_q  <= wr_ptr;
            tap_idx_q  <= '0;
            rd_valid_q <= 1'b1;
            rd_last_q  <= (LAST_TAP == '0);
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (rd_ready) begin
            if (tap_idx_q == LAST_TAP) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end else begin
              // Natural ADDR_W-bit wrap takes 0 back to the top of the buffer.
              rd_addr_q <= rd_addr_q - ADDR_ONE;
              tap_idx_q <= tap_idx_q + TAP_ONE;
              rd_last_q <= ((tap_idx_q + TAP_ONE) == LAST_TAP);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tap_idx  = tap_idx_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_delay_line_read_seq.sv
// Directed table-driven bench for delay_line_read_seq (TAPS=3/ADDR_W=3) plus a
// hand-written TAPS=1/ADDR_W=2 corner instance.
module tb_delay_line_read_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, rd_ready;
  logic [2:0] wr_ptr, rd_addr;
  logic [1:0] tap_idx;
  logic       rd_valid, rd_last, busy, done;

  logic       c_start, c_ready;
  logic [1:0] c_wp, c_addr;
  logic [0:0] c_tap;
  logic       c_valid, c_last, c_busy, c_done;

  delay_line_read_seq #(.ADDR_W(3), .TAPS(3), .TAP_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_ptr(wr_ptr),
    .rd_addr(rd_addr), .tap_idx(tap_idx), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy), .done(done)
  );

  delay_line_read_seq #(.ADDR_W(2), .TAPS(1), .TAP_W(1)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .wr_ptr(c_wp),
    .rd_addr(c_addr), .tap_idx(c_tap), .rd_valid(c_valid),
    .rd_ready(c_ready), .rd_last(c_last), .busy(c_busy), .done(c_done)
  );

  typedef struct {
    logic       rst, st;
    logic [2:0] wp;
    logic       rdy;
    logic       v;
    logic [2:0] a;
    logic [1:0] k;
    logic       l, b, d;
    logic       all;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic rst, input logic st, input logic [2:0] wp,
                     input logic rdy, input logic v, input logic [2:0] a,
                     input logic [1:0] k, input logic l, input logic b,
                     input logic d, input logic all);
    vec_t r;
    r.rst = rst; r.st = st; r.wp = wp; r.rdy = rdy; r.v = v; r.a = a;
    r.k = k; r.l = l; r.b = b; r.d = d; r.all = all;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_ready = 1'b0; wr_ptr = '0;
    c_start = 1'b0; c_ready = 1'b0; c_wp = '0;

    // rst st wp rdy | v a k l b d all
    add(1,1,5,1, 0,0,0,0,0,0,1);
    add(0,0,0,0, 0,0,0,0,0,0,1);
    // basic run from 5
    add(0,1,5,1, 1,5,0,0,1,0,0);
    add(0,0,0,1, 1,4,1,0,1,0,0);
    add(0,0,0,1, 1,3,2,1,1,0,0);
    add(0,0,0,1, 0,0,0,0,0,1,0);
    add(0,0,0,1, 0,0,0,0,0,0,0);
    // wrap-around from 1
    add(0,1,1,1, 1,1,0,0,1,0,0);
    add(0,0,0,1, 1,0,1,0,1,0,0);
    add(0,0,0,1, 1,7,2,1,1,0,0);
    add(0,0,0,1, 0,0,0,0,0,1,0);
    add(0,0,0,1, 0,0,0,0,0,0,0);
    // backpressure from 6: ready 1,0,0,1,1
    add(0,1,6,0, 1,6,0,0,1,0,0);
    add(0,0,0,1, 1,5,1,0,1,0,0);
    add(0,0,0,0, 1,5,1,0,1,0,0);
    add(0,0,0,0, 1,5,1,0,1,0,0);
    add(0,0,0,1, 1,4,2,1,1,0,0);
    add(0,0,0,1, 0,0,0,0,0,1,0);
    add(0,0,0,1, 0,0,0,0,0,0,0);
    // ignored starts in RUN, then start in the done cycle
    add(0,1,3,1, 1,3,0,0,1,0,0);
    add(0,1,7,1, 1,2,1,0,1,0,0);
    add(0,1,0,1, 1,1,2,1,1,0,0);
    add(0,1,4,1, 0,0,0,0,0,1,0);
    add(0,1,2,1, 1,2,0,0,1,0,0);
    add(0,0,0,1, 1,1,1,0,1,0,0);
    add(0,0,0,1, 1,0,2,1,1,0,0);
    add(0,0,0,1, 0,0,0,0,0,1,0);
    add(0,0,0,1, 0,0,0,0,0,0,0);
    // reset after the second transfer, then restart from 0
    add(0,1,4,1, 1,4,0,0,1,0,0);
    add(0,0,0,1, 1,3,1,0,1,0,0);
    add(0,0,0,1, 1,2,2,1,1,0,0);
    add(1,0,0,1, 0,0,0,0,0,0,1);
    add(0,0,0,1, 0,0,0,0,0,0,1);
    add(0,1,0,1, 1,0,0,0,1,0,0);
    add(0,0,0,1, 1,7,1,0,1,0,0);
    add(0,0,0,1, 1,6,2,1,1,0,0);
    add(0,0,0,1, 0,0,0,0,0,1,0);
    add(0,0,0,1, 0,0,0,0,0,0,0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; start = vecs[i].st;
      wr_ptr = vecs[i].wp; rd_ready = vecs[i].rdy;
      @(posedge clk); #1;
      chk("rd_valid", i, 32'(rd_valid), 32'(vecs[i].v));
      chk("rd_last",  i, 32'(rd_last),  32'(vecs[i].l));
      chk("busy",     i, 32'(busy),     32'(vecs[i].b));
      chk("done",     i, 32'(done),     32'(vecs[i].d));
      if (vecs[i].v || vecs[i].all) begin
        chk("rd_addr", i, 32'(rd_addr), 32'(vecs[i].a));
        chk("tap_idx", i, 32'(tap_idx), 32'(vecs[i].k));
      end
    end

    // TAPS=1 corner: single address with rd_last, done the next cycle
    @(negedge clk); reset = 1'b0; c_start = 1'b1; c_wp = 2'd3; c_ready = 1'b1;
    @(posedge clk); #1;
    chk("c_valid", 100, 32'(c_valid), 32'd1);
    chk("c_addr",  100, 32'(c_addr),  32'd3);
    chk("c_tap",   100, 32'(c_tap),   32'd0);
    chk("c_last",  100, 32'(c_last),  32'd1);
    chk("c_busy",  100, 32'(c_busy),  32'd1);
    @(negedge clk); c_start = 1'b0; c_wp = 2'd0;
    @(posedge clk); #1;
    chk("c_done",  101, 32'(c_done),  32'd1);
    chk("c_valid", 101, 32'(c_valid), 32'd0);
    chk("c_busy",  101, 32'(c_busy),  32'd0);
    chk("c_last",  101, 32'(c_last),  32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("c_done",  102, 32'(c_done),  32'd0);

    // TAPS=1 with a stall: address 2 held until ready
    @(negedge clk); c_start = 1'b1; c_wp = 2'd2; c_ready = 1'b0;
    @(posedge clk); #1;
    chk("c_addr",  103, 32'(c_addr),  32'd2);
    chk("c_last",  103, 32'(c_last),  32'd1);
    @(negedge clk); c_start = 1'b0;
    @(posedge clk); #1;
    chk("c_valid", 104, 32'(c_valid), 32'd1);
    chk("c_addr",  104, 32'(c_addr),  32'd2);
    chk("c_last",  104, 32'(c_last),  32'd1);
    chk("c_done",  104, 32'(c_done),  32'd0);
    @(negedge clk); c_ready = 1'b1;
    @(posedge clk); #1;
    chk("c_done",  105, 32'(c_done),  32'd1);
    chk("c_valid", 105, 32'(c_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
